// File: rtl/maj59_voter.sv
// Registered 59-input majority/threshold voter: y0 is 1 one clock after the
// ones-count of x0..x58 reaches THRESHOLD. A synchronous active-low reset clears y0.
module maj59_voter #(
  parameter int unsigned THRESHOLD = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  input  logic x6,
  input  logic x7,
  input  logic x8,
  input  logic x9,
  input  logic x10,
  input  logic x11,
  input  logic x12,
  input  logic x13,
  input  logic x14,
  input  logic x15,
  input  logic x16,
  input  logic x17,
  input  logic x18,
  input  logic x19,
  input  logic x20,
  input  logic x21,
  input  logic x22,
  input  logic x23,
  input  logic x24,
  input  logic x25,
  input  logic x26,
  input  logic x27,
  input  logic x28,
  input  logic x29,
  input  logic x30,
  input  logic x31,
  input  logic x32,
  input  logic x33,
  input  logic x34,
  input  logic x35,
  input  logic x36,
  input  logic x37,
  input  logic x38,
  input  logic x39,
  input  logic x40,
  input  logic x41,
  input  logic x42,
  input  logic x43,
  input  logic x44,
  input  logic x45,
  input  logic x46,
  input  logic x47,
  input  logic x48,
  input  logic x49,
  input  logic x50,
  input  logic x51,
  input  logic x52,
  input  logic x53,
  input  logic x54,
  input  logic x55,
  input  logic x56,
  input  logic x57,
  input  logic x58,
  output logic y0
);

  localparam logic [5:0] THR = 6'(THRESHOLD);

  logic [58:0] x_s;
  logic [63:0] x_pad_s;
  logic [5:0]  hw_s;
  logic        y_d;
  logic        y_q;

  // Ones-count of an 8-bit slice; eight of these feed the final 6-bit sum.
  function automatic logic [3:0] pop8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  assign x_s = {x58, x57, x56, x55, x54, x53, x52, x51, x50,
                x49, x48, x47, x46, x45, x44, x43, x42, x41, x40,
                x39, x38, x37, x36, x35, x34, x33, x32, x31, x30,
                x29, x28, x27, x26, x25, x24, x23, x22, x21, x20,
                x19, x18, x17, x16, x15, x14, x13, x12, x11, x10,
                x9,  x8,  x7,  x6,  x5,  x4,  x3,  x2,  x1,  x0};

  // The top slice is zero-padded so all eight slices have the same shape.
  assign x_pad_s = {5'd0, x_s};

  // Popcount and threshold compare.
  always_comb begin
    hw_s = 6'd0;
    for (int g = 0; g < 8; g++) begin
      hw_s = hw_s + {2'd0, pop8(x_pad_s[g*8 +: 8])};
    end
    if (hw_s >= THR) begin
      y_d = 1'b1;
    end else begin
      y_d = 1'b0;
    end
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y0 = y_q;

endmodule

// File: tb/tb_maj59_voter.sv
// Self-checking bench for maj59_voter: directed vector table for reset, extremes,
// threshold boundary, wiring and latency, then biased random vectors vs a popcount model.
module tb_maj59_voter;

  logic        clk;
  logic        rst_n;
  logic [58:0] x_v;
  logic        y0;

  int checks;
  int errors;

  typedef struct {
    logic        rst_n;
    logic [58:0] x;
    logic        exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  maj59_voter #(.THRESHOLD(30)) dut (
    .clk(clk), .rst_n(rst_n),
    .x0(x_v[0]),   .x1(x_v[1]),   .x2(x_v[2]),   .x3(x_v[3]),   .x4(x_v[4]),
    .x5(x_v[5]),   .x6(x_v[6]),   .x7(x_v[7]),   .x8(x_v[8]),   .x9(x_v[9]),
    .x10(x_v[10]), .x11(x_v[11]), .x12(x_v[12]), .x13(x_v[13]), .x14(x_v[14]),
    .x15(x_v[15]), .x16(x_v[16]), .x17(x_v[17]), .x18(x_v[18]), .x19(x_v[19]),
    .x20(x_v[20]), .x21(x_v[21]), .x22(x_v[22]), .x23(x_v[23]), .x24(x_v[24]),
    .x25(x_v[25]), .x26(x_v[26]), .x27(x_v[27]), .x28(x_v[28]), .x29(x_v[29]),
    .x30(x_v[30]), .x31(x_v[31]), .x32(x_v[32]), .x33(x_v[33]), .x34(x_v[34]),
    .x35(x_v[35]), .x36(x_v[36]), .x37(x_v[37]), .x38(x_v[38]), .x39(x_v[39]),
    .x40(x_v[40]), .x41(x_v[41]), .x42(x_v[42]), .x43(x_v[43]), .x44(x_v[44]),
    .x45(x_v[45]), .x46(x_v[46]), .x47(x_v[47]), .x48(x_v[48]), .x49(x_v[49]),
    .x50(x_v[50]), .x51(x_v[51]), .x52(x_v[52]), .x53(x_v[53]), .x54(x_v[54]),
    .x55(x_v[55]), .x56(x_v[56]), .x57(x_v[57]), .x58(x_v[58]),
    .y0(y0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic prev_exp;
  logic prev_valid;

  // Drive at the falling edge, confirm y0 has not moved early, clock, then check.
  task automatic step(input logic r, input logic [58:0] x, input logic exp, input string name);
    @(negedge clk);
    rst_n = r;
    x_v   = x;
    #1;
    if (prev_valid) begin
      checks++;
      if (y0 !== prev_exp) begin
        errors++;
        $display("FAIL hold/%s: y0=%b before edge, required %b", name, y0, prev_exp);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (y0 !== exp) begin
      errors++;
      $display("FAIL %s: y0=%b, required %b (x=%h rst_n=%b)", name, y0, exp, x, r);
    end
    prev_exp   = exp;
    prev_valid = 1'b1;
  endtask

  function automatic logic model(input logic r, input logic [58:0] x);
    if (!r) return 1'b0;
    return ($countones(x) >= 30) ? 1'b1 : 1'b0;
  endfunction

  task automatic add(input logic r, input logic [58:0] x, input logic exp, input string name);
    vec_t v;
    v.rst_n = r;
    v.x     = x;
    v.exp   = exp;
    v.name  = name;
    tbl.push_back(v);
  endtask

  logic [58:0] ones;
  logic [58:0] zeros;
  logic [58:0] hw29;
  logic [58:0] even_m;
  logic [58:0] odd_m;

  initial begin
    checks     = 0;
    errors     = 0;
    prev_valid = 1'b0;
    prev_exp   = 1'b0;
    rst_n      = 1'b0;
    zeros      = '0;
    ones       = '1;
    hw29       = '0;
    even_m     = '0;
    odd_m      = '0;
    for (int i = 0; i < 29; i++) hw29[i] = 1'b1;
    for (int i = 0; i < 59; i++) begin
      if (i % 2 == 0) even_m[i] = 1'b1;
      else            odd_m[i]  = 1'b1;
    end
    x_v = ones;

    add(1'b0, ones, 1'b0, "reset_0");
    add(1'b0, ones, 1'b0, "reset_1");
    add(1'b0, ones, 1'b0, "reset_2");
    add(1'b1, ones, 1'b1, "release_all1");
    add(1'b1, zeros, 1'b0, "all0");
    add(1'b1, ones, 1'b1, "all1");
    add(1'b1, hw29, 1'b0, "hw29");
    add(1'b1, hw29 | (59'd1 << 58), 1'b1, "hw30_x58");
    add(1'b1, (hw29 | (59'd1 << 58)) & ~59'd1, 1'b0, "hw29_clear_x0");
    add(1'b1, even_m, 1'b1, "even_bits");
    add(1'b1, odd_m, 1'b0, "odd_bits");
    add(1'b1, odd_m | 59'd1, 1'b1, "odd_plus_x0");
    for (int i = 0; i < 4; i++) begin
      add(1'b1, zeros, 1'b0, "toggle0");
      add(1'b1, ones, 1'b1, "toggle1");
    end
    add(1'b0, ones, 1'b0, "midop_reset");
    add(1'b1, ones, 1'b1, "resume_all1");
    add(1'b1, zeros, 1'b0, "resume_all0");
    add(1'b1, ones, 1'b1, "resume_all1b");

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].x, tbl[i].exp, tbl[i].name);
    end

    // Single-bit walk: each port alone on top of hw=29 must tip the vote.
    for (int b = 29; b < 59; b++) begin
      step(1'b1, hw29 | (59'd1 << b), 1'b1, "walk_tip");
      step(1'b1, hw29, 1'b0, "walk_base");
    end

    // Random vectors with ones-count concentrated around the threshold.
    for (int n = 0; n < 10000; n++) begin
      logic [58:0] rv;
      int          k;
      logic        r;
      rv = '0;
      if ($urandom_range(0, 9) == 0) begin
        rv = {$urandom(), $urandom()} >> 5;
      end else begin
        k = $urandom_range(25, 34);
        while ($countones(rv) < k) rv[$urandom_range(0, 58)] = 1'b1;
      end
      r = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step(r, rv, model(r, rv), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
